// File: rtl/reg_priority_encoder.sv
// reg_priority_encoder
//
// Parameterized N-input priority encoder with registered outputs. Reports
// the index of the highest-priority asserted request bit on y and whether
// any request bit is asserted on z. Results appear one clock after w is
// sampled with en high.
//
// Parameters:
//   N         - number of request inputs (2..256, any value)
//   MSB_FIRST - 1: bit N-1 has highest priority, 0: bit 0 has highest priority
//
// Ports:
//   clk - clock, all state updates on the rising edge
//   rst - asynchronous active-high reset, clears y and z immediately
//   en  - sample enable; when low the output registers hold
//   w   - request vector, N bits
//   y   - registered winning index, $clog2(N) bits
//   z   - registered any-request flag
module reg_priority_encoder #(
  parameter int N         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [N-1:0]         w,
  output logic [$clog2(N)-1:0] y,
  output logic                 z
);

  localparam int YW = $clog2(N);

  logic [YW-1:0] y_next;
  logic          z_next;

  // The scan order is chosen so that the last hit is the winner: scanning
  // upward leaves the highest set bit, scanning downward leaves the lowest.
  // Since only real bit positions are visited, y_next can never exceed N-1,
  // and with no bit set it keeps its default of zero.
  always_comb begin
    y_next = '0;
    z_next = |w;
    if (MSB_FIRST) begin
      for (int i = 0; i < N; i++) begin
        if (w[i]) y_next = YW'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (w[i]) y_next = YW'(i);
      end
    end
  end

  // Output registers are the only state; en gates sampling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y <= '0;
      z <= 1'b0;
    end else if (en) begin
      y <= y_next;
      z <= z_next;
    end
  end

endmodule

// File: tb/tb_reg_priority_encoder.sv
// tb_reg_priority_encoder
//
// Self-checking bench for reg_priority_encoder. Three instances are
// exercised: N=4 MSB-first, N=4 LSB-first and N=5 MSB-first. Stimulus pushes
// the expected response into a per-instance queue; a monitor pops and
// compares one entry shortly after each rising edge.
module tb_reg_priority_encoder;

  typedef struct {
    logic [4:0] w;
    int         y;
    logic       z;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;

  logic       en_a, en_b, en_c;
  logic [3:0] w_a, w_b;
  logic [4:0] w_c;
  logic [1:0] y_a, y_b;
  logic [2:0] y_c;
  logic       z_a, z_b, z_c;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  int compared   = 0;
  int mismatched = 0;

  // Hand-computed MSB-first results for w = 0..15 on the N=4 instance.
  int sweep_y[16] = '{0, 0, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 3, 3, 3, 3};

  always #5 clk = ~clk;

  reg_priority_encoder #(.N(4), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .w(w_a), .y(y_a), .z(z_a)
  );

  reg_priority_encoder #(.N(4), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .w(w_b), .y(y_b), .z(z_b)
  );

  reg_priority_encoder #(.N(5), .MSB_FIRST(1'b1)) dut_c (
    .clk(clk), .rst(rst), .en(en_c), .w(w_c), .y(y_c), .z(z_c)
  );

  // Reference for the N=5 MSB-first instance: highest set bit wins.
  function automatic int ref_msb5(input logic [4:0] v);
    int r;
    r = 0;
    for (int i = 4; i >= 0; i--) begin
      if (v[i]) begin
        r = i;
        break;
      end
    end
    return r;
  endfunction

  task automatic check_output(input string name, input logic [4:0] w,
                              input int act_y, input logic act_z,
                              input int exp_y, input logic exp_z);
    compared++;
    if (act_y !== exp_y || act_z !== exp_z) begin
      mismatched++;
      $display("[TB] FAIL %s w=%b: got y=%0d z=%b, expected y=%0d z=%b",
               name, w, act_y, act_z, exp_y, exp_z);
    end
  endtask

  // Drives one cycle of stimulus on the chosen instance and records the
  // response expected after the next rising edge.
  task automatic apply_stimulus(input int inst, input logic en,
                                input logic [4:0] w, input int ey,
                                input logic ez);
    exp_t e;
    @(negedge clk);
    e.w = w;
    e.y = ey;
    e.z = ez;
    case (inst)
      0: begin en_a = en; w_a = w[3:0]; q_a.push_back(e); end
      1: begin en_b = en; w_b = w[3:0]; q_b.push_back(e); end
      default: begin en_c = en; w_c = w; q_c.push_back(e); end
    endcase
  endtask

  // Monitor: one result per instance per clock, checked 1 time unit after
  // the edge so the registers have settled.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      check_output("a_msb4", e.w, int'(y_a), z_a, e.y, e.z);
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      check_output("b_lsb4", e.w, int'(y_b), z_b, e.y, e.z);
    end
    if (q_c.size() > 0) begin
      e = q_c.pop_front();
      check_output("c_msb5", e.w, int'(y_c), z_c, e.y, e.z);
      compared++;
      if (y_c > 3'd4) begin
        mismatched++;
        $display("[TB] FAIL c_range: got y=%0d, expected y<=4", y_c);
      end
    end
  end

  initial begin
    logic [4:0] rv;
    rst  = 1'b1;
    en_a = 1'b1; w_a = 4'b1111;
    en_b = 1'b0; w_b = 4'b0000;
    en_c = 1'b0; w_c = 5'b00000;

    // Reset holds outputs at zero despite en=1 and all requests set.
    #1;
    check_output("rst_immediate", 5'b01111, int'(y_a), z_a, 0, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check_output("rst_held", 5'b01111, int'(y_a), z_a, 0, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    q_a.push_back('{5'b01111, 3, 1'b1});

    // Sweep all 16 patterns with en=1.
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(0, 1'b1, 5'(i), sweep_y[i], (i != 0));
    end

    // Enable hold: register keeps 2 while en is low and w changes.
    apply_stimulus(0, 1'b1, 5'b00100, 2, 1'b1);
    repeat (3) apply_stimulus(0, 1'b0, 5'b00001, 2, 1'b1);
    apply_stimulus(0, 1'b1, 5'b00001, 0, 1'b1);
    apply_stimulus(0, 1'b0, 5'b00000, 0, 1'b1);

    // LSB-first priority direction.
    apply_stimulus(1, 1'b1, 5'b01010, 1, 1'b1);
    apply_stimulus(1, 1'b1, 5'b01000, 3, 1'b1);
    apply_stimulus(1, 1'b1, 5'b00000, 0, 1'b0);
    apply_stimulus(1, 1'b1, 5'b00001, 0, 1'b1);
    apply_stimulus(1, 1'b1, 5'b01111, 0, 1'b1);
    apply_stimulus(1, 1'b1, 5'b00110, 1, 1'b1);
    apply_stimulus(1, 1'b0, 5'b00000, 1, 1'b1);

    // Non-power-of-two width: directed top bit, then random vectors.
    apply_stimulus(2, 1'b1, 5'b10000, 4, 1'b1);
    apply_stimulus(2, 1'b1, 5'b11111, 4, 1'b1);
    apply_stimulus(2, 1'b1, 5'b00000, 0, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      rv = 5'($urandom_range(0, 31));
      apply_stimulus(2, 1'b1, rv, ref_msb5(rv), (rv != 5'b0));
    end
    apply_stimulus(2, 1'b0, 5'b00000, ref_msb5(rv), (rv != 5'b0));

    // Asynchronous reset pulse between edges.
    apply_stimulus(0, 1'b1, 5'b01001, 3, 1'b1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_output("rst_async", 5'b01001, int'(y_a), z_a, 0, 1'b0);
    #2;
    rst = 1'b0;
    apply_stimulus(0, 1'b1, 5'b01001, 3, 1'b1);

    repeat (3) @(posedge clk);
    #2;
    compared++;
    if (q_a.size() + q_b.size() + q_c.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: got %0d pending, expected 0",
               q_a.size() + q_b.size() + q_c.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
